// File: rtl/ac97_capture_receiver.sv
// AC97 SDATA_IN deserializer: locks to SYNC, decodes the slot 0 tag, and extracts
// slot 1/2 status read-back and slot 3/4 PCM record samples with a valid/ready output.
module ac97_capture_receiver #(
  parameter int SAMPLE_WIDTH = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync,
  input  logic                    sdata_in,
  output logic                    codec_ready,
  output logic [6:0]              status_addr,
  output logic [15:0]             status_data,
  output logic                    status_valid,
  output logic [SAMPLE_WIDTH-1:0] pcm_left,
  output logic [SAMPLE_WIDTH-1:0] pcm_right,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    overflow,
  output logic                    sync_err,
  input  logic                    err_clear
);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              n_q, n_d, cur_n;
  logic                    sync_q, sync_rise;
  logic [18:0]             shift_q;
  logic [19:0]             word;
  logic [3:0]              slot_vld_q;
  logic [6:0]              addr_hold_q;
  logic [SAMPLE_WIDTH-1:0] left_hold_q;
  logic                    in_frame, tag_stb, s1_stb, s2_stb, s3_stb, s4_stb;
  logic                    sync_err_set, status_load, pcm_offer, pcm_load, ovf_set;

  assign sync_rise = sync & ~sync_q;
  // The word completing on this edge, including the bit being sampled right now.
  assign word      = {shift_q, sdata_in};
  // Any SYNC rise (wrap or restart) makes the current bit n=0.
  assign cur_n     = sync_rise ? 8'd0 : n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a latch behind.
    state_d = state_q;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (sync_rise) begin
          state_d = FRAME;
          n_d     = 8'd1;
        end
      end
      FRAME: begin
        if (sync_rise) begin
          n_d = 8'd1;
        end else if (n_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          n_d = n_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_frame     = (state_q == FRAME) || sync_rise;
    tag_stb      = in_frame && (cur_n == 8'd15);
    s1_stb       = in_frame && (cur_n == 8'd35);
    s2_stb       = in_frame && (cur_n == 8'd55);
    s3_stb       = in_frame && (cur_n == 8'd75);
    s4_stb       = in_frame && (cur_n == 8'd95);
    sync_err_set = (state_q == FRAME) && sync_rise && (n_q != 8'd0);
    status_load  = s2_stb && slot_vld_q[3] && slot_vld_q[2];
    pcm_offer    = s4_stb && slot_vld_q[1] && slot_vld_q[0];
    pcm_load     = pcm_offer && (!pcm_valid || pcm_ready);
    ovf_set      = pcm_offer && pcm_valid && !pcm_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 1'b0;
      shift_q      <= '0;
      codec_ready  <= 1'b0;
      slot_vld_q   <= '0;
      addr_hold_q  <= '0;
      left_hold_q  <= '0;
      status_addr  <= '0;
      status_data  <= '0;
      status_valid <= 1'b0;
      pcm_left     <= '0;
      pcm_right    <= '0;
      pcm_valid    <= 1'b0;
      overflow     <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      sync_q       <= sync;
      shift_q      <= word[18:0];
      status_valid <= status_load;
      if (tag_stb) begin
        codec_ready <= word[15];
        slot_vld_q  <= word[14:11];
      end
      if (s1_stb) addr_hold_q <= word[18:12];
      if (s3_stb) left_hold_q <= word[19 -: SAMPLE_WIDTH];
      if (status_load) begin
        status_addr <= addr_hold_q;
        status_data <= word[19:4];
      end
      // A load on a transfer cycle keeps pcm_valid high for the new pair.
      if (pcm_load) begin
        pcm_left  <= left_hold_q;
        pcm_right <= word[19 -: SAMPLE_WIDTH];
        pcm_valid <= 1'b1;
      end else if (pcm_valid && pcm_ready) begin
        pcm_valid <= 1'b0;
      end
      overflow <= ovf_set      | (overflow & ~err_clear);
      sync_err <= sync_err_set | (sync_err & ~err_clear);
    end
  end

endmodule

// File: tb/tb_ac97_capture_receiver.sv
// Randomized bench: frames are built from tag/slot values, and the expected output
// events are derived from frame positions, then compared against the DUT every cycle.
module tb_ac97_capture_receiver;

  logic        clk = 1'b0;
  logic        rst, sync, sdata_in, pcm_ready, err_clear;
  logic        codec_ready, status_valid, pcm_valid, overflow, sync_err;
  logic [6:0]  status_addr;
  logic [15:0] status_data;
  logic [19:0] pcm_left, pcm_right;
  logic [15:0] pcm_left16, pcm_right16;
  logic        codec_ready16, status_valid16, pcm_valid16, overflow16, sync_err16;
  logic [6:0]  status_addr16;
  logic [15:0] status_data16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ac97_capture_receiver #(.SAMPLE_WIDTH(20)) u_dut (
    .clk(clk), .rst(rst), .sync(sync), .sdata_in(sdata_in),
    .codec_ready(codec_ready), .status_addr(status_addr), .status_data(status_data),
    .status_valid(status_valid), .pcm_left(pcm_left), .pcm_right(pcm_right),
    .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .overflow(overflow),
    .sync_err(sync_err), .err_clear(err_clear)
  );

  ac97_capture_receiver #(.SAMPLE_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .sync(sync), .sdata_in(sdata_in),
    .codec_ready(codec_ready16), .status_addr(status_addr16), .status_data(status_data16),
    .status_valid(status_valid16), .pcm_left(pcm_left16), .pcm_right(pcm_right16),
    .pcm_valid(pcm_valid16), .pcm_ready(pcm_ready), .overflow(overflow16),
    .sync_err(sync_err16), .err_clear(err_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Events the driver knows will be decoded on the next rising edge.
  logic        ev_tag, ev_cr, ev_status, ev_pcm, ev_serr;
  logic [6:0]  ev_addr;
  logic [15:0] ev_data;
  logic [19:0] ev_l, ev_r;

  // Reference state of what the outputs must show.
  logic        m_cr, m_sv, m_pv, m_ovf, m_serr;
  logic [6:0]  m_addr;
  logic [15:0] m_data;
  logic [19:0] m_l, m_r;

  always @(posedge clk) begin
    if (rst) begin
      m_cr <= 0; m_sv <= 0; m_pv <= 0; m_ovf <= 0; m_serr <= 0;
      m_addr <= 0; m_data <= 0; m_l <= 0; m_r <= 0;
    end else begin
      m_sv <= ev_status;
      if (ev_status) begin
        m_addr <= ev_addr;
        m_data <= ev_data;
      end
      if (ev_tag) m_cr <= ev_cr;
      if (ev_pcm && (!m_pv || pcm_ready)) begin
        m_pv <= 1; m_l <= ev_l; m_r <= ev_r;
      end else if (m_pv && pcm_ready) begin
        m_pv <= 0;
      end
      if (ev_pcm && m_pv && !pcm_ready) m_ovf <= 1;
      else if (err_clear)               m_ovf <= 0;
      if (ev_serr)        m_serr <= 1;
      else if (err_clear) m_serr <= 0;
    end
  end

  logic mon_on = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      check("pcm_valid",     pcm_valid,     m_pv);
      check("pcm_left",      pcm_left,      m_l);
      check("pcm_right",     pcm_right,     m_r);
      check("status_valid",  status_valid,  m_sv);
      check("status_addr",   status_addr,   m_addr);
      check("status_data",   status_data,   m_data);
      check("codec_ready",   codec_ready,   m_cr);
      check("overflow",      overflow,      m_ovf);
      check("sync_err",      sync_err,      m_serr);
      check("pcm_valid16",   pcm_valid16,   m_pv);
      check("pcm_left16",    pcm_left16,    m_l[19:4]);
      check("pcm_right16",   pcm_right16,   m_r[19:4]);
    end
  end

  int dut_n = -1;       // next frame index the DUT expects; -1 when idle
  logic ready_rand = 1'b0;

  task automatic step(input logic s, input logic d);
    sync = s;
    sdata_in = d;
    if (ready_rand) pcm_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    ev_tag = 0; ev_status = 0; ev_pcm = 0; ev_serr = 0; err_clear = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'($urandom_range(0, 1)));
    dut_n = -1;
  endtask

  task automatic do_reset(input int k);
    rst = 1'b1;
    repeat (k) step(1'b0, 1'b0);
    rst = 1'b0;
    dut_n = -1;
  endtask

  task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4, input int len);
    logic [19:0] slot [1:4];
    slot[1] = s1; slot[2] = s2; slot[3] = s3; slot[4] = s4;
    for (int n = 0; n < len; n++) begin
      logic b;
      int   k, p;
      k = (n - 16) / 20 + 1;
      p = 19 - (n - 16) % 20;
      if (n < 16)      b = tag[15 - n];
      else if (k <= 4) b = slot[k][p];
      else             b = 1'($urandom_range(0, 1));
      if (n == 0) ev_serr = (dut_n > 0);
      if (n == 15) begin
        ev_tag = 1; ev_cr = tag[15];
      end
      if (n == 55 && tag[14] && tag[13]) begin
        ev_status = 1; ev_addr = s1[18:12]; ev_data = s2[19:4];
      end
      if (n == 95 && tag[12] && tag[11]) begin
        ev_pcm = 1; ev_l = s3; ev_r = s4;
      end
      step(n < 16, b);
    end
    dut_n = (len == 256) ? 0 : len;
  endtask

  initial begin
    logic [15:0] tag;
    int          len;
    ev_tag = 0; ev_cr = 0; ev_status = 0; ev_pcm = 0; ev_serr = 0;
    ev_addr = 0; ev_data = 0; ev_l = 0; ev_r = 0;
    sync = 0; sdata_in = 0; pcm_ready = 1; err_clear = 0; rst = 1;
    @(negedge clk);
    do_reset(4);
    mon_on = 1'b1;
    check("rst_pcm_left",    pcm_left,    20'h0);
    check("rst_status_data", status_data, 16'h0);
    check("rst_codec_ready", codec_ready, 1'b0);
    idle(10);

    // Steady frames, ready held high, status then a frame with slot 2 invalid.
    repeat (3) send_frame(16'hF800, 20'h26000, 20'hABCD0, 20'h12345, 20'hFFFCE, 256);
    send_frame(16'hD800, 20'h55000, 20'h11110, 20'h0ABCD, 20'h54321, 256);
    idle(4);

    // Backpressure: second pair dropped, then drained and flags cleared.
    pcm_ready = 0;
    send_frame(16'hF800, 20'h01000, 20'h22220, 20'hAAAAA, 20'h55555, 256);
    send_frame(16'hF800, 20'h02000, 20'h33330, 20'h13579, 20'h2468A, 256);
    idle(5);
    pcm_ready = 1;
    idle(3);
    err_clear = 1;
    idle(3);

    // SYNC injected mid-frame at several positions.
    send_frame(16'h8000, 20'h03000, 20'h44440, 20'h11111, 20'h22222, 100);
    send_frame(16'hF800, 20'h04000, 20'h55550, 20'h33333, 20'h44444, 256);
    send_frame(16'hF800, 20'h05000, 20'h66660, 20'h77777, 20'h88888, 90);
    send_frame(16'hF800, 20'h06000, 20'h77770, 20'h99999, 20'hBBBBB, 256);
    send_frame(16'hF800, 20'h07000, 20'h88880, 20'hCCCCC, 20'hDDDDD, 50);
    send_frame(16'hF800, 20'h08000, 20'h99990, 20'hEEEEE, 20'h01234, 256);
    err_clear = 1;
    idle(3);

    // Slot 3 valid only: nothing offered, outputs keep their values.
    send_frame(16'h9000, 20'h09000, 20'hAAAA0, 20'hFEDCB, 20'hA9876, 256);
    idle(3);

    // Randomized frames, truncations, gaps and consumer stalls.
    ready_rand = 1'b1;
    for (int f = 0; f < 14; f++) begin
      tag = ($urandom_range(0, 1) != 0) ? 16'hF800 : 16'($urandom);
      len = ($urandom_range(0, 3) == 0 && f < 13) ? $urandom_range(20, 255) : 256;
      send_frame(tag, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), len);
      if (len == 256 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
      if ($urandom_range(0, 5) == 0) err_clear = 1;
    end
    ready_rand = 1'b0;
    pcm_ready = 1;
    idle(3);

    // Reset mid-frame with a pair held drops everything; relock afterwards.
    pcm_ready = 0;
    send_frame(16'hF800, 20'h0A000, 20'hBBBB0, 20'h12345, 20'hFFFCE, 256);
    send_frame(16'hF800, 20'h0B000, 20'hCCCC0, 20'h54321, 20'h0FFFF, 150);
    do_reset(3);
    check("midrst_pcm_valid", pcm_valid, 1'b0);
    check("midrst_pcm_left",  pcm_left,  20'h0);
    pcm_ready = 1;
    idle(4);
    send_frame(16'hF800, 20'h26000, 20'hABCD0, 20'h12345, 20'hFFFCE, 256);
    idle(4);
    check("final_pcm_left", pcm_left, 20'h12345);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ac97_capture_receiver.md
# ac97_capture_receiver

Bit-clock-domain deserializer for the AC97 SDATA_IN stream, the codec-to-controller direction of the AC97 link. Locks to frame boundaries from SYNC, decodes the slot 0 tag, and extracts the slot 1/2 status read-back and the slot 3/4 PCM record samples. Sits beside the AC97 output controller and feeds stereo record samples into the record-direction async FIFO toward the CPU via a valid/ready handshake.

## Interface
- SAMPLE_WIDTH, 20: PCM output width. Output is the top SAMPLE_WIDTH bits of the 20-bit slot, truncated with no rounding. Legal range 1..20.
- clk  in  1  AC97 bit clock; every register in the block is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sync  in  1  AC97 SYNC as driven by the controller, sampled on rising clk.
- sdata_in  in  1  codec serial data, MSB first, sampled on rising clk.
- codec_ready  out  1  tag bit 15 of the most recent complete tag.
- status_addr  out  7  slot 1 bits 18:12.
- status_data  out  16  slot 2 bits 19:4.
- status_valid  out  1  one-cycle pulse when a new status pair is latched.
- pcm_left  out  SAMPLE_WIDTH  slot 3 sample.
- pcm_right  out  SAMPLE_WIDTH  slot 4 sample.
- pcm_valid  out  1  a stereo sample pair is held for the consumer.
- pcm_ready  in  1  consumer (FIFO not full) accepts the pair.
- overflow  out  1  sticky: a pair was dropped because the previous pair had not been accepted.
- sync_err  out  1  sticky: SYNC rose at an unexpected frame position.
- err_clear  in  1  clears overflow and sync_err.

## Operation
- States: IDLE and FRAME. An 8-bit frame index n (0..255) counts bits within a frame. A 20-bit shift register captures sdata_in MSB-first.
- The sync rising edge is detected as sync high with a registered sync of 0.
- IDLE: on a sync rising edge, capture the bit sampled on that same edge as n=0, then go to FRAME with n=1.
- FRAME: each cycle, shift in one bit and increment n.
  - If n=255 and no sync rising edge arrives on the next cycle, go to IDLE.
  - A sync rising edge exactly at wrap (n would be 0) continues seamlessly.
- Tag bit layout:
  - n=0: codec ready.
  - n=1: slot 1 valid. n=2: slot 2 valid. n=3: slot 3 valid. n=4: slot 4 valid.
  - n=5..15 are ignored.
  - The tag is latched after n=15. codec_ready updates then.
- Slot k (1..12) occupies n = 16+20(k-1) through 35+20(k-1). Slots 5..12 are ignored.
  - Slot 1 is latched at n=35. Slot 2 at n=55. Slot 3 at n=75. Slot 4 at n=95.
- Status path: after n=55, if tag slot1 and slot2 valid bits are both 1, load status_addr and status_data and pulse status_valid. Otherwise leave them unchanged with no pulse.
- PCM path: after n=95, if tag slot3 and slot4 valid bits are both 1, offer a new pair.
  - If pcm_valid=0, or pcm_valid=1 with pcm_ready=1 this cycle: load the pair and set pcm_valid.
  - If pcm_valid=1 with pcm_ready=0: drop the new pair, keep the held pair unchanged, and set overflow.
- Handshake: a transfer occurs on any cycle with pcm_valid and pcm_ready both high.
  - pcm_valid clears after a transfer unless a new pair loads on that same cycle.
  - pcm_left and pcm_right stay stable while pcm_valid=1 and pcm_ready=0.
- Sync rising edge in FRAME at any n other than the wrap:
  - set sync_err;
  - discard the partial frame, with no status or PCM output from it;
  - restart with the current bit taken as n=0.
- err_clear clears the sticky flags. If err_clear and a new error occur on the same cycle, the flag is set (set wins).

## Timing
- Reset values: every output is 0, the state is IDLE, n=0, and the latched tag is 0.
- Reset asserted mid-frame drops the partial frame and any held pair. The block relocks on the next sync rising edge after rst deasserts.
- status_valid is high on the cycle after the clk edge that samples n=55. Duration is exactly one cycle.
- pcm_valid rises on the cycle after the clk edge that samples n=95. Latency from the last slot 4 bit to pcm_valid is 1 cycle.
- codec_ready updates 1 cycle after the n=15 edge.
- With pcm_ready held high, there is exactly one pcm_valid cycle per valid frame, i.e. one every 256 clk.

## Test plan
- Reset: hold rst high for 4 clk → all outputs 0. Deassert rst with sync low → block stays in IDLE with no pulses.
- Frames with tag 0xF800 (ready, slots 1–4 valid), slot3=0x12345, slot4=0xFFFCE, pcm_ready=1:
  - pcm_left=0x12345 and pcm_right=0xFFFCE, valid 1 cycle after bit 95;
  - one pulse per 256 clk;
  - codec_ready=1.
- Status frame with slot1 addr 0x26, slot2 data 0xABCD → status_addr=0x26 and status_data=0xABCD, status_valid a single pulse. Clearing the slot 2 tag bit → no pulse.
- Backpressure: pcm_ready=0 across two valid frames → first pair held stable, second pair dropped, overflow=1. Then pcm_ready=1 → first pair transfers and pcm_valid drops. err_clear → overflow=0.
- Sync rising edge injected at n=100 → sync_err=1, no PCM from the truncated frame; the next full frame is decoded correctly.
- Tag with slot 3 valid only (0x9000) → no pcm_valid, existing outputs unchanged. SAMPLE_WIDTH=16 build → slot3=0x12345 yields pcm_left=0x1234.
